// File: rtl/spi_host.sv
// spi_host: mode-0 SPI initiator issuing one 16-bit register write/read frame per request.
// Define SPI_HOST_MISO_SYNC_EN to put a two-flop synchroniser in front of the MISO sampler.
module spi_host #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic       req_we_i,
    input  logic [6:0] req_addr_i,
    input  logic [7:0] req_wdata_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_rdata_o,
    output logic       busy_o,
    output logic       sclk_o,
    output logic       cs_o,
    output logic       mosi_o,
    input  logic       miso_i
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] PHASE_LAST = CW'(CLK_DIV - 1);

    if (CLK_DIV < 2) begin : g_div_check
        $error("spi_host: CLK_DIV must be at least 2");
    end

    typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [5:0]      bit_q, bit_d;
    logic [15:0]     tx_q;
    logic [7:0]      rx_q;
    logic            we_q;
    logic            miso_s;
    logic            accept;
    logic            phase_end;
    logic            sample;
    logic            ready_d;

`ifdef SPI_HOST_MISO_SYNC_EN
    if (CLK_DIV < 3) begin : g_sync_check
        $error("spi_host: CLK_DIV must be at least 3 with the MISO synchroniser");
    end

    logic [1:0] miso_sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) miso_sync_q <= 2'b00;
        else         miso_sync_q <= {miso_sync_q[0], miso_i};
    end

    assign miso_s = miso_sync_q[1];
`else
    assign miso_s = miso_i;
`endif

    assign accept = req_valid_i & req_ready_o;

    // bit_q counts SCLK half-periods; its LSB is the level SCLK shows in that half.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        phase_end = (cnt_q == PHASE_LAST);
        sample    = (state_q == SHIFT) && bit_q[0] && phase_end;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (accept) state_d = LEAD;
            end
            LEAD: begin
                cnt_d = phase_end ? '0 : cnt_q + 1'b1;
                if (phase_end) state_d = SHIFT;
            end
            SHIFT: begin
                cnt_d = phase_end ? '0 : cnt_q + 1'b1;
                if (phase_end) begin
                    if (bit_q == 6'd31) begin
                        bit_d   = '0;
                        state_d = TRAIL;
                    end else begin
                        bit_d = bit_q + 6'd1;
                    end
                end
            end
            TRAIL: begin
                cnt_d = phase_end ? '0 : cnt_q + 1'b1;
                if (phase_end) state_d = GAP;
            end
            GAP: begin
                cnt_d = phase_end ? '0 : cnt_q + 1'b1;
                if (phase_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
        end
    end

    // Outputs trail the state by one cycle; ready drops on the accepting edge itself.
    assign ready_d = (state_q == IDLE) && !accept;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tx_q        <= '0;
            rx_q        <= '0;
            we_q        <= 1'b0;
            cs_o        <= 1'b1;
            sclk_o      <= 1'b0;
            mosi_o      <= 1'b0;
            req_ready_o <= 1'b1;
            busy_o      <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
        end else begin
            if (accept) begin
                tx_q <= {req_we_i, req_addr_i, req_we_i ? req_wdata_i : 8'h00};
                we_q <= req_we_i;
            end else if (sample) begin
                tx_q <= {tx_q[14:0], 1'b0};
            end
            if (sample) rx_q <= {rx_q[6:0], miso_s};
            cs_o   <= !(state_q inside {LEAD, SHIFT, TRAIL});
            sclk_o <= (state_q == SHIFT) && bit_q[0];
            if (state_q inside {LEAD, SHIFT}) mosi_o <= tx_q[15];
            req_ready_o <= ready_d;
            busy_o      <= !ready_d;
            // First idle cycle after GAP is the only time state is IDLE with ready still low.
            rsp_valid_o <= (state_q == IDLE) && !req_ready_o;
            if ((state_q == IDLE) && !req_ready_o) rsp_rdata_o <= we_q ? 8'h00 : rx_q;
        end
    end

endmodule

// File: tb/tb_spi_host.sv
// tb_spi_host: scoreboard bench for spi_host, main instance at CLK_DIV=4 plus a fast-divider instance.
module tb_spi_host;

    localparam int D  = 4;
`ifdef SPI_HOST_MISO_SYNC_EN
    localparam int D2 = 3;
`else
    localparam int D2 = 2;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_we, miso;
    logic [6:0] req_addr;
    logic [7:0] req_wdata;
    logic       req_ready_o, rsp_valid_o, busy_o, sclk_o, cs_o, mosi_o;
    logic [7:0] rsp_rdata_o;

    logic       d2_valid, d2_we, d2_miso;
    logic [6:0] d2_addr;
    logic [7:0] d2_wdata;
    logic       d2_ready_o, d2_rsp_valid_o, d2_busy_o, d2_sclk_o, d2_cs_o, d2_mosi_o;
    logic [7:0] d2_rdata_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [15:0] exp_frame_q[$];
    logic [7:0]  exp_rdata_q[$];
    logic [7:0]  slave_q[$];
    int          acc_q[$];

    logic        cs_prev, sclk_prev, in_b2b;
    logic [15:0] mon_frame;
    logic [7:0]  slave_byte;
    int          mon_bits, cs_low, slave_idx, last_rise, b2b_seen, rsp_cnt;

    spi_host #(.CLK_DIV(D)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .busy_o(busy_o),
        .sclk_o(sclk_o), .cs_o(cs_o), .mosi_o(mosi_o), .miso_i(miso)
    );

    spi_host #(.CLK_DIV(D2)) dut2 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(d2_valid), .req_ready_o(d2_ready_o), .req_we_i(d2_we),
        .req_addr_i(d2_addr), .req_wdata_i(d2_wdata),
        .rsp_valid_o(d2_rsp_valid_o), .rsp_rdata_o(d2_rdata_o), .busy_o(d2_busy_o),
        .sclk_o(d2_sclk_o), .cs_o(d2_cs_o), .mosi_o(d2_mosi_o), .miso_i(d2_miso)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor plus mode-0 slave: MISO changes after each SCLK fall, data byte on frame bits 7:0.
    always @(negedge clk) begin
        if (!rst_n) begin
            cs_prev   = 1'b1;
            sclk_prev = 1'b0;
            miso      = 1'b0;
            mon_bits  = 0;
        end else begin
            if (!cs_o && cs_prev) begin
                mon_bits   = 0;
                mon_frame  = '0;
                cs_low     = 0;
                slave_idx  = 0;
                miso       = 1'b0;
                slave_byte = (slave_q.size() > 0) ? slave_q.pop_front() : 8'h00;
                if (in_b2b) begin
                    // GAP phase, plus the idle cycle that accepts and the registered cs update.
                    if (b2b_seen > 0) checkOutput("cs_gap", cyc - last_rise, D + 2);
                    b2b_seen++;
                end
            end
            if (!cs_o) cs_low++;
            if (sclk_o && !sclk_prev) begin
                if (mon_bits == 0 && acc_q.size() > 0) checkOutput("first_rise", cyc - acc_q[0], 2 * D + 1);
                mon_frame = {mon_frame[14:0], mosi_o};
                mon_bits++;
            end
            if (!sclk_o && sclk_prev) begin
                slave_idx++;
                miso = (slave_idx >= 8 && slave_idx < 16) ? slave_byte[15 - slave_idx] : 1'b0;
            end
            if (cs_o && !cs_prev) begin
                last_rise = cyc;
                if (exp_frame_q.size() == 0) checkOutput("frame_extra", 1, 0);
                else checkOutput("mosi_frame", mon_frame, exp_frame_q.pop_front());
                checkOutput("sclk_rises", mon_bits, 16);
                checkOutput("cs_low_len", cs_low, 34 * D);
            end
            if (rsp_valid_o) begin
                rsp_cnt++;
                checkOutput("rsp_ready", req_ready_o, 1);
                if (exp_rdata_q.size() == 0) checkOutput("rsp_extra", 1, 0);
                else begin
                    checkOutput("rsp_rdata", rsp_rdata_o, exp_rdata_q.pop_front());
                    if (acc_q.size() > 0) checkOutput("rsp_latency", cyc - acc_q.pop_front(), 35 * D + 1);
                end
            end
            cs_prev   = cs_o;
            sclk_prev = sclk_o;
        end
    end

    task automatic applyStimulus(input logic we, input logic [6:0] addr, input logic [7:0] wdata,
                                 input logic [7:0] sdata, input bit hold, input bit chk_b2b);
        bit ok = 0;
        @(negedge clk);
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (req_ready_o) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checkOutput("accept_timeout", 0, 1);
            req_valid = 1'b0;
        end else begin
            if (chk_b2b) checkOutput("b2b_accept_rsp", rsp_valid_o, 1);
            exp_frame_q.push_back({we, addr, we ? wdata : 8'h00});
            exp_rdata_q.push_back(we ? 8'h00 : sdata);
            slave_q.push_back(sdata);
            acc_q.push_back(cyc + 1);
            @(negedge clk);
            if (!hold) req_valid = 1'b0;
        end
    endtask

    task automatic waitDone();
        bit done = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (exp_rdata_q.size() == 0 && req_ready_o) begin
                done = 1;
                break;
            end
        end
        if (!done) checkOutput("done_timeout", 0, 1);
    endtask

    initial begin
        int saved_rsp;
        int r1, r2, acc2, lat2, bits2, low2;
        bit got2;
        logic [15:0] frame2;
        logic prev2;

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        d2_valid = 1'b0; d2_we = 1'b0; d2_addr = '0; d2_wdata = '0; d2_miso = 1'b0;
        in_b2b = 1'b0; b2b_seen = 0; rsp_cnt = 0; last_rise = 0; cs_low = 0;
        repeat (3) @(negedge clk);
        checkOutput("rst_cs", cs_o, 1);
        checkOutput("rst_sclk", sclk_o, 0);
        checkOutput("rst_mosi", mosi_o, 0);
        checkOutput("rst_ready", req_ready_o, 1);
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_rsp_valid", rsp_valid_o, 0);
        checkOutput("rst_rdata", rsp_rdata_o, 8'h00);
        rst_n = 1'b1;

        applyStimulus(1'b1, 7'h05, 8'h3C, 8'h00, 0, 0);
        checkOutput("busy_in_frame", busy_o, 1);
        waitDone();
        applyStimulus(1'b0, 7'h18, 8'hFF, 8'hA5, 0, 0);
        waitDone();
        applyStimulus(1'b0, 7'h18, 8'h00, 8'h5A, 0, 0);
        waitDone();

        in_b2b = 1'b1;
        applyStimulus(1'b1, 7'h21, 8'h96, 8'h00, 1, 0);
        applyStimulus(1'b0, 7'h6B, 8'h00, 8'hC7, 0, 1);
        waitDone();
        in_b2b = 1'b0;
        checkOutput("b2b_frames", b2b_seen, 2);

        saved_rsp = rsp_cnt;
        applyStimulus(1'b1, 7'h12, 8'h34, 8'h00, 0, 0);
        repeat (40) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_we    = 1'($urandom_range(0, 1));
            req_addr  = 7'($urandom);
            req_wdata = 8'($urandom);
            @(negedge clk);
        end
        req_valid = 1'b0;
        waitDone();
        repeat (10) @(negedge clk);
        checkOutput("midframe_rsp_count", rsp_cnt - saved_rsp, 1);

        applyStimulus(1'b1, 7'h33, 8'hC3, 8'h00, 0, 0);
        for (int i = 0; i < 500 && mon_bits < 9; i++) @(negedge clk);
        checkOutput("reach_bit9", mon_bits >= 9, 1);
        saved_rsp = rsp_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midrst_cs", cs_o, 1);
        checkOutput("midrst_sclk", sclk_o, 0);
        checkOutput("midrst_ready", req_ready_o, 1);
        rst_n = 1'b1;
        exp_frame_q.delete(); exp_rdata_q.delete(); slave_q.delete(); acc_q.delete();
        repeat (200) @(negedge clk);
        checkOutput("midrst_no_rsp", rsp_cnt - saved_rsp, 0);
        applyStimulus(1'b1, 7'h44, 8'h5B, 8'h00, 0, 0);
        waitDone();

        @(negedge clk);
        d2_we = 1'b1; d2_addr = 7'h7F; d2_wdata = 8'hFF; d2_valid = 1'b1;
        checkOutput("d2_ready", d2_ready_o, 1);
        acc2 = cyc + 1;
        @(negedge clk);
        d2_valid = 1'b0;
        r1 = -1; r2 = -1; lat2 = 0; bits2 = 0; low2 = 0; got2 = 0; frame2 = '0; prev2 = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (d2_sclk_o && !prev2) begin
                frame2 = {frame2[14:0], d2_mosi_o};
                bits2++;
                if (r1 < 0) r1 = cyc;
                else if (r2 < 0) r2 = cyc;
            end
            if (!d2_cs_o) low2++;
            prev2 = d2_sclk_o;
            if (d2_rsp_valid_o) begin
                lat2 = cyc - acc2;
                got2 = 1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("d2_rsp_seen", got2, 1);
        checkOutput("d2_frame", frame2, 16'hFFFF);
        checkOutput("d2_bits", bits2, 16);
        checkOutput("d2_first_rise", r1 - acc2, 2 * D2 + 1);
        checkOutput("d2_sclk_period", r2 - r1, 2 * D2);
        checkOutput("d2_cs_low", low2, 34 * D2);
        checkOutput("d2_latency", lat2, 35 * D2 + 1);
        checkOutput("d2_rdata", d2_rdata_o, 8'h00);

        repeat (5) @(negedge clk);
        checkOutput("sb_empty", exp_rdata_q.size() + exp_frame_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
